fm_wm_transform: RTL

- Computes the product of the feature matrix (FM) and the weight matrix (WM), one dot product at a time.
- Writes each result entry into the FM×WM product memory through that memory's write port (write_row, write_col, wr_en, fm_wm_in).
- Reads operands element-serially from the FM and WM memories, which are external, have 1-cycle read latency and are word-addressed.
- Sits directly upstream of the FM×WM product memory. Asserts done when all FEATURE_ROWS × WEIGHT_COLS entries are written, so the downstream aggregation stage can start reading rows.

---
 rtl/fm_wm_pkg.sv | 10 +
 rtl/fm_wm_transform_mac.sv | 21 ++
 rtl/fm_wm_transform.sv | 122 ++++++++++++
 3 files changed

// File: rtl/fm_wm_pkg.sv
// fm_wm_pkg: shared state encoding and default sizes for the FM x WM product engine
package fm_wm_pkg;
  typedef enum logic [2:0] {IDLE, ISSUE, LAST, WRITE, DONE} state_t;
  localparam int FEATURE_ROWS = 6;
  localparam int FEATURE_COLS = 96;
  localparam int WEIGHT_COLS = 3;
  localparam int DATA_WIDTH = 5;
  localparam int DOT_PROD_WIDTH = 16;
  localparam int ADDRESS_WIDTH = 13;
endpackage

// File: rtl/fm_wm_transform_mac.sv
// fm_wm_mac: unsigned multiply-accumulate with clear and enable, wrapping accumulator
module fm_wm_mac #(
  parameter int DATA_WIDTH = 5,
  parameter int DOT_PROD_WIDTH = 16
)(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clr,
  input  logic                      en,
  input  logic [DATA_WIDTH-1:0]     a,
  input  logic [DATA_WIDTH-1:0]     b,
  output logic [DOT_PROD_WIDTH-1:0] acc
);
  logic [2*DATA_WIDTH-1:0] prod;
  assign prod = a * b;
  // clear wins over accumulate; the sum wraps modulo 2^DOT_PROD_WIDTH
  always_ff @(posedge clk) begin
    if (rst || clr) acc <= '0;
    else if (en) acc <= acc + DOT_PROD_WIDTH'(prod);
  end
endmodule

// File: rtl/fm_wm_transform.sv
// fm_wm_transform: sequences element-serial dot products of FM x WM into the product memory
module fm_wm_transform import fm_wm_pkg::*; #(
  parameter int FEATURE_ROWS = fm_wm_pkg::FEATURE_ROWS,
  parameter int FEATURE_COLS = fm_wm_pkg::FEATURE_COLS,
  parameter int WEIGHT_COLS = fm_wm_pkg::WEIGHT_COLS,
  parameter int DATA_WIDTH = fm_wm_pkg::DATA_WIDTH,
  parameter int DOT_PROD_WIDTH = fm_wm_pkg::DOT_PROD_WIDTH,
  parameter int ADDRESS_WIDTH = fm_wm_pkg::ADDRESS_WIDTH,
  parameter int FEATURE_WIDTH = $clog2(FEATURE_ROWS),
  parameter int WEIGHT_WIDTH = $clog2(WEIGHT_COLS)
)(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  output logic [ADDRESS_WIDTH-1:0]  fm_read_addr,
  output logic [ADDRESS_WIDTH-1:0]  wm_read_addr,
  output logic                      read_en,
  input  logic [DATA_WIDTH-1:0]     fm_data_in,
  input  logic [DATA_WIDTH-1:0]     wm_data_in,
  output logic [FEATURE_WIDTH-1:0]  write_row,
  output logic [WEIGHT_WIDTH-1:0]   write_col,
  output logic                      wr_en,
  output logic [DOT_PROD_WIDTH-1:0] fm_wm_out
);
  localparam int KW = $clog2(FEATURE_COLS);
  state_t state;
  logic [FEATURE_WIDTH-1:0] r, nr;
  logic [WEIGHT_WIDTH-1:0] c, nc;
  logic [KW-1:0] k;
  logic valid, last_entry;
  logic [DOT_PROD_WIDTH-1:0] acc;
  // next product entry in row-major order
  always_comb begin
    nc = (c == WEIGHT_WIDTH'(WEIGHT_COLS-1)) ? '0 : c + 1'b1;
    nr = (nc == '0) ? r + 1'b1 : r;
    last_entry = (r == FEATURE_WIDTH'(FEATURE_ROWS-1)) && (c == WEIGHT_WIDTH'(WEIGHT_COLS-1));
  end
  // read data arrives one cycle after each read strobe
  always_ff @(posedge clk) begin
    valid <= rst ? 1'b0 : read_en;
  end
  fm_wm_mac #(.DATA_WIDTH(DATA_WIDTH), .DOT_PROD_WIDTH(DOT_PROD_WIDTH)) u_mac (
    .clk(clk),
    .rst(rst),
    .clr(state == WRITE || state == IDLE),
    .en(valid),
    .a(fm_data_in),
    .b(wm_data_in),
    .acc(acc)
  );
  // control FSM; strobes and addresses are registered, reads issued for the state being entered
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      r <= '0;
      c <= '0;
      k <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      read_en <= 1'b0;
      wr_en <= 1'b0;
      fm_read_addr <= '0;
      wm_read_addr <= '0;
      write_row <= '0;
      write_col <= '0;
      fm_wm_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state <= ISSUE;
            busy <= 1'b1;
            r <= '0;
            c <= '0;
            k <= '0;
            read_en <= 1'b1;
            fm_read_addr <= '0;
            wm_read_addr <= '0;
          end
        end
        ISSUE: begin
          wr_en <= 1'b0;
          if (k == KW'(FEATURE_COLS-1)) begin
            state <= LAST;
            read_en <= 1'b0;
          end else begin
            k <= k + 1'b1;
            fm_read_addr <= fm_read_addr + 1'b1;
            wm_read_addr <= wm_read_addr + ADDRESS_WIDTH'(WEIGHT_COLS);
          end
        end
        LAST: state <= WRITE;
        WRITE: begin
          wr_en <= 1'b1;
          write_row <= r;
          write_col <= c;
          fm_wm_out <= acc;
          k <= '0;
          c <= nc;
          r <= last_entry ? '0 : nr;
          if (last_entry) state <= DONE;
          else begin
            state <= ISSUE;
            read_en <= 1'b1;
            fm_read_addr <= ADDRESS_WIDTH'(int'(nr) * FEATURE_COLS);
            wm_read_addr <= ADDRESS_WIDTH'(nc);
          end
        end
        DONE: begin
          wr_en <= 1'b0;
          done <= 1'b1;
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
